pixel_stream_capture: RTL and testbench

- Producer-side front end for the colour-recognition path. Receives a camera byte stream: vsync, href, and a byte strobe already synchronised to `clock`.
- Assembles byte pairs into 2N-bit pixels and tracks x/y coordinates.
- Presents each pixel through a valid/ready register to downstream consumers (pixel_matcher channel extraction, colour accumulators).
- Flags frame completion and overflow. The camera cannot be stalled.

---
 rtl/pixel_pkg.sv | 27 ++
 rtl/byte_pair_assembler.sv | 39 +++
 rtl/pixel_stream_capture.sv | 155 +++++++++++++++
 tb/tb_pixel_stream_capture.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared types and defaults for the camera pixel capture path.
package pixel_pkg;

   localparam int unsigned DefaultN        = 8;
   localparam int unsigned DefaultHPixels  = 320;
   localparam int unsigned DefaultVLines   = 240;
   localparam int unsigned StateBits       = 3;

   typedef enum logic [StateBits-1:0] {
      StIdle,
      StWaitVs,
      StWaitFrame,
      StLineWait,
      StCapHi,
      StCapLo
   } cap_state_e;

   typedef enum logic {
      PhaseHi,
      PhaseLo
   } byte_phase_e;

   function automatic int unsigned pixel_width(input int unsigned n);
      return 2 * n;
   endfunction

endpackage

// File: rtl/byte_pair_assembler.sv
// Pairs consecutive camera bytes into one word; the first byte of a pair is the MSB half.
module byte_pair_assembler
   import pixel_pkg::*;
#(
   parameter int unsigned N = DefaultN
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           clear,
   input  logic           strobe,
   input  logic [N-1:0]   data,
   output logic           pair_valid,
   output logic [2*N-1:0] word
);

   byte_phase_e  phase_q;
   logic [N-1:0] hi_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         phase_q <= PhaseHi;
         hi_q    <= '0;
      end else if (clear) begin
         // A dangling high byte is dropped whenever the line ends or capture stops.
         phase_q <= PhaseHi;
      end else if (strobe) begin
         if (phase_q == PhaseHi) begin
            hi_q    <= data;
            phase_q <= PhaseLo;
         end else begin
            phase_q <= PhaseHi;
         end
      end
   end

   assign pair_valid = strobe && !clear && (phase_q == PhaseLo);
   assign word       = {hi_q, data};

endmodule

// File: rtl/pixel_stream_capture.sv
// Camera byte-stream capture: pixel assembly, x/y tracking, valid/ready output register.
// Optional window crop when PIXEL_CAPTURE_CROP_EN is defined.
module pixel_stream_capture
   import pixel_pkg::*;
#(
   parameter int unsigned N        = DefaultN,
   parameter int unsigned H_PIXELS = DefaultHPixels,
   parameter int unsigned V_LINES  = DefaultVLines,
   parameter int unsigned XW       = 9,
   parameter int unsigned YW       = 8
`ifdef PIXEL_CAPTURE_CROP_EN
   ,
   parameter int unsigned CROP_X0  = 0,
   parameter int unsigned CROP_Y0  = 0,
   parameter int unsigned CROP_W   = H_PIXELS,
   parameter int unsigned CROP_H   = V_LINES
`endif
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           cam_vsync,
   input  logic           cam_href,
   input  logic           cam_strobe,
   input  logic [N-1:0]   cam_data,
   input  logic           enable,
   input  logic           pixel_ready,
   output logic [2*N-1:0] pixel,
   output logic [XW-1:0]  pixel_x,
   output logic [YW-1:0]  pixel_y,
   output logic           pixel_valid,
   output logic           frame_done,
   output logic           overflow,
   output logic           line_error
);

   localparam int unsigned PW = pixel_width(N);

   cap_state_e    state_q;
   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;

   logic          capturing;
   logic          asm_clear;
   logic          pair_valid;
   logic [PW-1:0] pair_word;
   logic [31:0]   x_ext;
   logic [31:0]   y_ext;
   logic          in_range;
   logic          in_window;
   logic [XW-1:0] out_x;
   logic [YW-1:0] out_y;

   assign capturing = (state_q == StCapHi) || (state_q == StCapLo);
   assign asm_clear = !capturing || !cam_href || cam_vsync;

   byte_pair_assembler #(
      .N (N)
   ) u_assembler (
      .clock      (clock),
      .reset      (reset),
      .clear      (asm_clear),
      .strobe     (cam_strobe),
      .data       (cam_data),
      .pair_valid (pair_valid),
      .word       (pair_word)
   );

   always_comb begin
      x_ext    = 32'(x_q);
      y_ext    = 32'(y_q);
      in_range = (x_ext < H_PIXELS) && (y_ext < V_LINES);
`ifdef PIXEL_CAPTURE_CROP_EN
      in_window = (x_ext >= CROP_X0) && (x_ext < CROP_X0 + CROP_W) &&
                  (y_ext >= CROP_Y0) && (y_ext < CROP_Y0 + CROP_H);
      out_x     = XW'(x_ext - CROP_X0);
      out_y     = YW'(y_ext - CROP_Y0);
`else
      in_window = 1'b1;
      out_x     = x_q;
      out_y     = y_q;
`endif
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         x_q         <= '0;
         y_q         <= '0;
         pixel       <= '0;
         pixel_x     <= '0;
         pixel_y     <= '0;
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         overflow    <= 1'b0;
         line_error  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (pixel_valid && pixel_ready) begin
            pixel_valid <= 1'b0;
         end
         unique case (state_q)
            StIdle: begin
               if (enable) state_q <= StWaitVs;
            end
            StWaitVs: begin
               // Never start mid-frame: wait for a blanking interval first.
               if (cam_vsync) state_q <= StWaitFrame;
            end
            StWaitFrame: begin
               if (!cam_vsync) begin
                  state_q    <= StLineWait;
                  x_q        <= '0;
                  y_q        <= '0;
                  overflow   <= 1'b0;
                  line_error <= 1'b0;
               end
            end
            StLineWait, StCapHi, StCapLo: begin
               if (cam_vsync) begin
                  frame_done <= 1'b1;
                  state_q    <= enable ? StWaitFrame : StIdle;
               end else if (state_q == StLineWait) begin
                  if (cam_href) begin
                     state_q <= StCapHi;
                     x_q     <= '0;
                  end
               end else if (!cam_href) begin
                  state_q <= StLineWait;
                  if (x_ext != H_PIXELS) line_error <= 1'b1;
                  if (y_ext < V_LINES) y_q <= y_q + 1'b1;
               end else if (cam_strobe && (state_q == StCapHi)) begin
                  state_q <= StCapLo;
               end else if (pair_valid) begin
                  state_q <= StCapHi;
                  if (x_ext < H_PIXELS) x_q <= x_q + 1'b1;
                  if (!in_range) begin
                     line_error <= 1'b1;
                  end else if (in_window) begin
                     if (pixel_valid && !pixel_ready) begin
                        overflow <= 1'b1;
                     end else begin
                        pixel       <= pair_word;
                        pixel_x     <= out_x;
                        pixel_y     <= out_y;
                        pixel_valid <= 1'b1;
                     end
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_stream_capture.sv
// Randomised bench for pixel_stream_capture on a 4x2 frame, checked against a behavioural model.
module tb_pixel_stream_capture;

   localparam int unsigned N  = 8;
   localparam int unsigned H  = 4;
   localparam int unsigned V  = 2;
   localparam int unsigned XW = 9;
   localparam int unsigned YW = 8;
`ifdef PIXEL_CAPTURE_CROP_EN
   localparam int unsigned CX0 = 1;
   localparam int unsigned CY0 = 0;
   localparam int unsigned CW  = 2;
   localparam int unsigned CH  = 2;
   localparam int A_COUNT  = 4;
   localparam int A_LAST_X = 1;
`else
   localparam int unsigned CX0 = 0;
   localparam int unsigned CY0 = 0;
   localparam int unsigned CW  = H;
   localparam int unsigned CH  = V;
   localparam int A_COUNT  = 8;
   localparam int A_LAST_X = 3;
`endif

   localparam int MIdle   = 0;
   localparam int MWaitHi = 1;
   localparam int MWaitLo = 2;
   localparam int MFrame  = 3;

   logic           clock;
   logic           reset;
   logic           cam_vsync;
   logic           cam_href;
   logic           cam_strobe;
   logic [N-1:0]   cam_data;
   logic           enable;
   logic           pixel_ready;
   logic [2*N-1:0] pixel;
   logic [XW-1:0]  pixel_x;
   logic [YW-1:0]  pixel_y;
   logic           pixel_valid;
   logic           frame_done;
   logic           overflow;
   logic           line_error;

   pixel_stream_capture #(
      .N        (N),
      .H_PIXELS (H),
      .V_LINES  (V),
      .XW       (XW),
      .YW       (YW)
`ifdef PIXEL_CAPTURE_CROP_EN
      ,
      .CROP_X0  (CX0),
      .CROP_Y0  (CY0),
      .CROP_W   (CW),
      .CROP_H   (CH)
`endif
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .cam_vsync   (cam_vsync),
      .cam_href    (cam_href),
      .cam_strobe  (cam_strobe),
      .cam_data    (cam_data),
      .enable      (enable),
      .pixel_ready (pixel_ready),
      .pixel       (pixel),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .pixel_valid (pixel_valid),
      .frame_done  (frame_done),
      .overflow    (overflow),
      .line_error  (line_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   // Expected-event strobes produced by the stimulus side from the frame rules.
   logic           ev_pix;
   logic [2*N-1:0] ev_val;
   logic [XW-1:0]  ev_x;
   logic [YW-1:0]  ev_y;
   logic           ev_lerr;
   logic           ev_fstart;
   logic           ev_fdone;

   int mode;
   int y_cnt;
   int ready_mode = 0;
   int fd_cnt = 0;
   logic [32:0] dut_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_xfer(input string name, input int idx, input logic [2*N-1:0] p,
                             input logic [XW-1:0] x, input logic [YW-1:0] y);
      logic [32:0] e;
      tests++;
      if (idx >= dut_q.size()) begin
         fails++;
         $display("FAIL %s: only %0d transfers seen, needed index %0d", name, dut_q.size(), idx);
      end else begin
         e = dut_q[idx];
         if (e !== {p, x, y}) begin
            fails++;
            $display("FAIL %s: got pix %h x %0d y %0d, expected pix %h x %0d y %0d", name,
                     e[32:17], e[16:8], e[7:0], p, x, y);
         end
      end
   endtask

   // Downstream ready: 0 = always ready, 1 = stalled, 2 = random.
   initial begin
      pixel_ready = 1'b0;
      forever begin
         @(negedge clock);
         if (ready_mode == 0)      pixel_ready = 1'b1;
         else if (ready_mode == 1) pixel_ready = 1'b0;
         else                      pixel_ready = ($urandom_range(3) != 0);
      end
   end

   // Model: single-slot output register plus sticky flags, compared every cycle.
   initial begin
      logic           m_valid;
      logic [2*N-1:0] m_pix;
      logic [XW-1:0]  m_x;
      logic [YW-1:0]  m_y;
      logic           m_ovf;
      logic           m_lerr;
      logic           m_fd;
      logic           prev_v;
      logic [32:0]    prev_o;
      m_valid = 0; m_pix = '0; m_x = '0; m_y = '0; m_ovf = 0; m_lerr = 0; m_fd = 0;
      prev_v = 0; prev_o = '0;
      forever begin
         @(posedge clock);
         if (reset && prev_v && pixel_ready) dut_q.push_back(prev_o);
         if (!reset) begin
            m_valid = 0; m_pix = '0; m_x = '0; m_y = '0; m_ovf = 0; m_lerr = 0; m_fd = 0;
         end else begin
            m_fd = ev_fdone;
            if (ev_fstart) begin
               m_ovf  = 0;
               m_lerr = 0;
            end
            if (ev_lerr) m_lerr = 1;
            if (m_valid && pixel_ready) m_valid = 0;
            if (ev_pix) begin
               if (m_valid) m_ovf = 1;
               else begin
                  m_valid = 1; m_pix = ev_val; m_x = ev_x; m_y = ev_y;
               end
            end
         end
         #1;
         check("valid", 32'(pixel_valid), 32'(m_valid));
         if (m_valid) begin
            check("pixel", 32'(pixel), 32'(m_pix));
            check("pixel_x", 32'(pixel_x), 32'(m_x));
            check("pixel_y", 32'(pixel_y), 32'(m_y));
         end
         check("overflow", 32'(overflow), 32'(m_ovf));
         check("line_error", 32'(line_error), 32'(m_lerr));
         check("frame_done", 32'(frame_done), 32'(m_fd));
         if (frame_done) fd_cnt++;
         prev_v = pixel_valid;
         prev_o = {pixel, pixel_x, pixel_y};
      end
   end

   task automatic tick();
      @(negedge clock);
      cam_strobe = 1'b0;
      ev_pix = 1'b0; ev_lerr = 1'b0; ev_fstart = 1'b0; ev_fdone = 1'b0;
   endtask

   task automatic set_enable(input logic en);
      tick();
      enable = en;
      if (en && mode == MIdle) mode = MWaitHi;
      tick();
      tick();
   endtask

   task automatic vsync_pulse();
      tick();
      cam_vsync = 1'b1;
      if (mode == MFrame) begin
         ev_fdone = 1'b1;
         mode = enable ? MWaitLo : MIdle;
      end else if (mode == MWaitHi) begin
         mode = MWaitLo;
      end
      repeat (3) tick();
      cam_vsync = 1'b0;
      if (mode == MWaitLo) begin
         ev_fstart = 1'b1;
         mode = MFrame;
         y_cnt = 0;
      end
      repeat (2) tick();
   endtask

   task automatic drive_line(input int nbytes, input logic rand_data, input int max_gap);
      logic [7:0] hi;
      logic [7:0] b;
      int npix;
      npix = 0;
      hi = '0;
      tick();
      cam_href = 1'b1;
      tick();
      tick();
      for (int i = 0; i < nbytes; i++) begin
         b = rand_data ? 8'($urandom) : ((i % 2 == 0) ? 8'h17 : 8'h46);
         cam_strobe = 1'b1;
         cam_data = b;
         if (i % 2 == 0) begin
            hi = b;
         end else if (mode == MFrame) begin
            if (npix < H && y_cnt < V) begin
               if (npix >= CX0 && npix < CX0 + CW && y_cnt >= CY0 && y_cnt < CY0 + CH) begin
                  ev_pix = 1'b1;
                  ev_val = {hi, b};
                  ev_x   = XW'(npix - CX0);
                  ev_y   = YW'(y_cnt - CY0);
               end
            end else begin
               ev_lerr = 1'b1;
            end
            npix++;
         end
         tick();
         repeat ($urandom_range(max_gap)) tick();
      end
      cam_href = 1'b0;
      if (mode == MFrame) begin
         if (npix != H) ev_lerr = 1'b1;
         if (y_cnt < V) y_cnt++;
      end
      tick();
      tick();
   endtask

   initial begin
      int q0;
      int f0;
      int nl;
      int lens[7] = '{8, 8, 8, 7, 9, 10, 6};
      reset = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_strobe = 1'b0; cam_data = '0;
      enable = 1'b0;
      ev_pix = 0; ev_val = '0; ev_x = '0; ev_y = '0; ev_lerr = 0; ev_fstart = 0; ev_fdone = 0;
      mode = MIdle; y_cnt = 0;
      repeat (3) tick();
      check("rst_valid", 32'(pixel_valid), 0);
      check("rst_pixel", 32'(pixel), 0);
      check("rst_xy", 32'({pixel_x, pixel_y}), 0);
      check("rst_flags", 32'({frame_done, overflow, line_error}), 0);
      reset = 1'b1;

      // 4x2 frame of 0x1746 with ready tied high.
      set_enable(1'b1);
      vsync_pulse();
      q0 = dut_q.size();
      drive_line(8, 1'b0, 1);
      drive_line(8, 1'b0, 1);
      f0 = fd_cnt;
      vsync_pulse();
      repeat (2) tick();
      check("A_count", 32'(dut_q.size() - q0), 32'(A_COUNT));
      check_xfer("A_first", q0, 16'h1746, 0, 0);
      check_xfer("A_last", q0 + A_COUNT - 1, 16'h1746, XW'(A_LAST_X), 1);
      check("A_frame_done", 32'(fd_cnt - f0), 1);

      // Disarm mid-frame, then re-arm while vsync is already low.
      drive_line(8, 1'b1, 2);
      set_enable(1'b0);
      drive_line(8, 1'b1, 2);
      vsync_pulse();
      set_enable(1'b1);
      q0 = dut_q.size();
      drive_line(8, 1'b1, 1);
      check("midframe_no_pix", 32'(dut_q.size()), 32'(q0));
      vsync_pulse();
      drive_line(8, 1'b0, 1);
      check_xfer("rearm_first", q0, 16'h1746, 0, 0);

      // Short line with an odd trailing byte.
      vsync_pulse();
      drive_line(7, 1'b0, 1);
      check("odd_line_error", 32'(line_error), 1);
      q0 = dut_q.size();
      drive_line(8, 1'b0, 1);
      check_xfer("after_odd_first", q0, 16'h1746, 0, 1);

      // Downstream stalled: first pixel held, later ones dropped.
      vsync_pulse();
      ready_mode = 1;
      drive_line(8, 1'b0, 2);
      check("stall_overflow", 32'(overflow), 1);
      check("stall_held_valid", 32'(pixel_valid), 1);
      check("stall_held_pixel", 32'({pixel, pixel_x}), 32'({16'h1746, 9'd0}));
      vsync_pulse();
      check("overflow_cleared", 32'(overflow), 0);

      // Asynchronous reset while waiting for a low byte.
      tick();
      cam_href = 1'b1;
      tick();
      tick();
      cam_strobe = 1'b1;
      cam_data = 8'hA5;
      tick();
      #2 reset = 1'b0;
      #1;
      check("async_rst_valid", 32'(pixel_valid), 0);
      check("async_rst_pixel", 32'(pixel), 0);
      check("async_rst_flags", 32'({frame_done, overflow, line_error}), 0);
      tick();
      tick();
      cam_href = 1'b0;
      reset = 1'b1;
      mode = enable ? MWaitHi : MIdle;
      y_cnt = 0;
      ready_mode = 0;
      q0 = dut_q.size();
      drive_line(8, 1'b1, 1);
      check("post_rst_no_pix", 32'(dut_q.size()), 32'(q0));
      vsync_pulse();
      drive_line(8, 1'b0, 1);
      check_xfer("post_rst_first", q0, 16'h1746, 0, 0);

      // Randomised frames: random data, gaps, ready, and line lengths.
      ready_mode = 2;
      for (int f = 0; f < 10; f++) begin
         vsync_pulse();
         nl = int'($urandom_range(3, 2));
         for (int l = 0; l < nl; l++) drive_line(lens[$urandom_range(6)], 1'b1, 2);
      end
      vsync_pulse();
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
      $fatal(1);
   end

endmodule
